// File: rtl/pa_cmd_scheduler.sv
// PA serial command channel scheduler: three one-entry request slots, fixed priority,
// a single command in flight with reply timeout, bounded retry and an enforced idle gap.

module pa_cmd_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (vld && !full) begin
      full <= 1'b1;
      dout <= din;
    end
endmodule

module pa_cmd_scheduler #(
  parameter int RSP_TIMEOUT = 500000,
  parameter int GAP_CYCLES  = 5000,
  parameter int MAX_RETRY   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   req_vld,
  input  logic [95:0]  req_data,
  output logic [2:0]   req_rdy,
  output logic [2:0]   resp_vld,
  output logic [2:0]   resp_err,
  output logic [39:0]  resp_data,
  output logic         send_en,
  output logic [31:0]  send_data,
  input  logic         recirve_vld,
  input  logic [39:0]  recieve_data,
  output logic         busy,
  output logic [7:0]   stray_cnt
);
  localparam int NUM_REQ = 3;
  localparam int CMD_W   = 32;
  localparam int RSP_W   = 40;
  localparam int OW      = 2;
  localparam int TW      = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam int GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(RSP_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  typedef struct packed {
    logic [NUM_REQ-1:0] vld;
    logic [NUM_REQ-1:0] err;
    logic [RSP_W-1:0]   data;
  } resp_t;

  state_t                         state, state_nxt;
  logic [OW-1:0]                  owner, pick;
  logic                           any_full;
  logic [NUM_REQ-1:0]             full, own_oh, clr;
  logic [NUM_REQ-1:0][CMD_W-1:0]  slot;
  logic [TW-1:0]                  tcnt;
  logic [GW-1:0]                  gcnt;
  logic [RW-1:0]                  retry;
  logic                           retry_pend;
  logic                           done, err, do_retry;
  resp_t                          rsp;

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_slot
      pa_cmd_slot #(.W(CMD_W)) u_slot (
        .clk  (clk),
        .rst_n(rst_n),
        .vld  (req_vld[i]),
        .clr  (clr[i]),
        .din  (req_data[CMD_W*i +: CMD_W]),
        .full (full[i]),
        .dout (slot[i])
      );
    end
  endgenerate

  assign req_rdy = ~full;

  // lowest index wins: scan from the top so the last hit is the highest priority
  always_comb begin
    pick     = '0;
    any_full = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (full[k]) begin
        pick     = OW'(k);
        any_full = 1'b1;
      end
  end

  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
  end

  assign clr = done ? own_oh : '0;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    err       = 1'b0;
    do_retry  = 1'b0;
    case (state)
      IDLE: if (any_full) state_nxt = SEND;
      SEND: state_nxt = WAIT;
      WAIT:
        if (recirve_vld) begin
          done      = 1'b1;
          state_nxt = GAP;
        end else if (tcnt == T_LAST) begin
          state_nxt = GAP;
          if (retry < R_MAX) do_retry = 1'b1;
          else begin
            done = 1'b1;
            err  = 1'b1;
          end
        end
      GAP:  if (gcnt == G_LAST) state_nxt = retry_pend ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      retry      <= '0;
      retry_pend <= 1'b0;
      tcnt       <= '0;
      gcnt       <= '0;
      send_en    <= 1'b0;
      send_data  <= '0;
      rsp        <= '0;
      stray_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      send_en <= (state_nxt == SEND);
      tcnt    <= (state == WAIT) ? tcnt + 1'b1 : '0;
      gcnt    <= (state == GAP)  ? gcnt + 1'b1 : '0;
      // send_data is captured on arbitration so it is valid during the strobe;
      // a retry re-sends the unchanged slot, so it simply holds
      if (state == IDLE && any_full) begin
        owner     <= pick;
        retry     <= '0;
        send_data <= slot[pick];
      end
      if (do_retry) begin
        retry      <= retry + 1'b1;
        retry_pend <= 1'b1;
      end
      if (state == SEND) retry_pend <= 1'b0;
      rsp.vld <= clr;
      rsp.err <= err ? own_oh : '0;
      if (done) rsp.data <= err ? '0 : recieve_data;
      if (recirve_vld && state != WAIT && stray_cnt != 8'hFF)
        stray_cnt <= stray_cnt + 1'b1;
    end

  assign resp_vld  = rsp.vld;
  assign resp_err  = rsp.err;
  assign resp_data = rsp.data;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pa_cmd_scheduler.sv
// Scoreboard bench for pa_cmd_scheduler: stimulus pushes expected sends/responses,
// a monitor pops and compares them, and a PA model answers according to a per-send plan.

module tb_pa_cmd_scheduler;
  localparam int T = 200;
  localparam int G = 20;
  localparam int R = 2;
  localparam int ERR_LAT = 3*T + 2*G + 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_vld = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_rdy, resp_vld, resp_err;
  logic [39:0] resp_data;
  logic        send_en, busy;
  logic [31:0] send_data;
  logic        recirve_vld;
  logic [39:0] recieve_data;
  logic [7:0]  stray_cnt;

  logic        pa_vld = 1'b0, stray_vld = 1'b0;
  logic [39:0] pa_data = '0, stray_data = '0;
  assign recirve_vld  = pa_vld | stray_vld;
  assign recieve_data = pa_vld ? pa_data : stray_data;

  pa_cmd_scheduler #(.RSP_TIMEOUT(T), .GAP_CYCLES(G), .MAX_RETRY(R)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .resp_vld(resp_vld), .resp_err(resp_err), .resp_data(resp_data),
    .send_en(send_en), .send_data(send_data),
    .recirve_vld(recirve_vld), .recieve_data(recieve_data),
    .busy(busy), .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; bit first; } exp_send_t;
  typedef struct { int idx; bit err; logic [39:0] data; int d; } exp_resp_t;
  typedef struct { int d; logic [39:0] data; } plan_t;

  exp_send_t exp_send[$];
  exp_resp_t exp_resp[$];
  plan_t     plan_q[$];

  int n_chk = 0, n_pass = 0;
  int stray_exp = 0;
  int round_no = 0, round_xfer = 0;

  logic [31:0] cfg_cmd [3];
  int          cfg_k   [3];
  int          cfg_d   [3];
  logic [39:0] cfg_rep [3];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", nm, cyc);
  endtask

  // Monitor: compares every send strobe and response pulse with the scoreboard.
  initial begin
    exp_send_t e;
    exp_resp_t r;
    int prev_send = -1, first_send = 0, last_send = 0, checked_round = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_send = -1;
      else begin
        if (send_en) begin
          if (exp_send.size() == 0) fail_now("unexpected_send");
          else begin
            e = exp_send.pop_front();
            check("send_data", send_data, e.data);
            if (e.first) begin
              first_send = cyc;
              if (round_no != checked_round) begin
                check("send_latency", cyc - round_xfer, 2);
                checked_round = round_no;
              end
            end
          end
          if (prev_send >= 0) check("send_gap", (cyc - prev_send) > G, 1);
          prev_send = cyc;
          last_send = cyc;
        end
        if (resp_vld != 3'b000) begin
          if (exp_resp.size() == 0) fail_now("unexpected_resp");
          else begin
            r = exp_resp.pop_front();
            check("resp_vld", resp_vld, 3'b001 << r.idx);
            check("resp_err", resp_err, r.err ? (3'b001 << r.idx) : 3'b000);
            check("resp_data", resp_data, r.data);
            check("rdy_rise", req_rdy[r.idx], 1);
            if (r.err) check("err_time", cyc - first_send, ERR_LAT);
            else       check("resp_time", cyc - last_send, r.d + 1);
          end
        end
      end
    end
  end

  // PA model: each send consumes one plan entry; d<0 means stay silent.
  initial begin
    plan_t p;
    forever begin
      @(negedge clk);
      if (rst_n && send_en && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        if (p.d > 0) begin
          repeat (p.d) @(negedge clk);
          pa_data = p.data;
          pa_vld  = 1'b1;
          @(negedge clk);
          pa_vld  = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || req_rdy != 3'b111) && t < 2000) begin @(negedge clk); t++; end
    if (busy || req_rdy != 3'b111) fail_now("idle_wait");
  endtask

  // Reference model: priority order among the requesting set, k timeouts per command,
  // MAX_RETRY+1 sends at most, error when every send times out.
  task automatic issue(input logic [2:0] mask);
    exp_send_t e;
    exp_resp_t r;
    plan_t     p;
    logic [2:0] rdy_exp;
    int n;
    wait_idle();
    for (int i = 0; i < 3; i++) if (mask[i]) begin
      n = (cfg_k[i] > R) ? R + 1 : cfg_k[i] + 1;
      for (int j = 0; j < n; j++) begin
        e.data = cfg_cmd[i]; e.first = (j == 0);
        exp_send.push_back(e);
        p.d = (j < cfg_k[i]) ? -1 : cfg_d[i]; p.data = cfg_rep[i];
        plan_q.push_back(p);
      end
      r.idx = i; r.err = (cfg_k[i] > R);
      r.data = r.err ? 40'h0 : cfg_rep[i]; r.d = cfg_d[i];
      exp_resp.push_back(r);
    end
    @(negedge clk);
    req_vld = mask;
    for (int i = 0; i < 3; i++) req_data[32*i +: 32] = cfg_cmd[i];
    round_xfer = cyc;
    round_no++;
    @(negedge clk);
    req_vld = '0;
    rdy_exp = ~mask;
    check("rdy_after_xfer", req_rdy, rdy_exp);
  endtask

  task automatic wait_resp();
    int t = 0;
    while (exp_resp.size() != 0 && t < 8000) begin @(negedge clk); t++; end
    if (exp_resp.size() != 0) begin
      fail_now("resp_wait");
      exp_resp.delete(); exp_send.delete(); plan_q.delete();
    end
  endtask

  task automatic wait_quiet();
    int t = 0;
    while (busy && t < G + 50) begin @(negedge clk); t++; end
    check("busy_end", busy, 0);
    check("sends_left", exp_send.size(), 0);
    check("stray_cnt", stray_cnt, stray_exp);
  endtask

  task automatic inject_stray();
    @(negedge clk);
    stray_data = {8'($urandom), $urandom};
    stray_vld  = 1'b1;
    @(negedge clk);
    stray_vld  = 1'b0;
    stray_exp++;
  endtask

  task automatic rand_cfg(input int kmax);
    for (int i = 0; i < 3; i++) begin
      cfg_cmd[i] = $urandom;
      cfg_k[i]   = $urandom_range(0, kmax);
      cfg_d[i]   = $urandom_range(1, T);
      cfg_rep[i] = {8'($urandom), $urandom};
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdy", req_rdy, 3'b111);
    check("rst_resp_vld", resp_vld, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_send_en", send_en, 0);
    check("rst_send_data", send_data, 0);
    check("rst_busy", busy, 0);
    check("rst_stray", stray_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single request on requester 1
    rand_cfg(0);
    cfg_cmd[1] = 32'h00040102; cfg_k[1] = 0; cfg_d[1] = 100; cfg_rep[1] = 40'h0A0B0C0D0E;
    issue(3'b010); wait_resp(); wait_quiet();

    // contention: all three in one cycle
    rand_cfg(0);
    cfg_cmd[0] = 32'h01010103; cfg_cmd[1] = 32'h00030102; cfg_cmd[2] = 32'h00040102;
    issue(3'b111); wait_resp(); wait_quiet();

    // requester 2 never answered: three sends then error
    rand_cfg(0);
    cfg_k[2] = 3;
    issue(3'b100); wait_resp(); wait_quiet();

    // one timeout then a reply 10 cycles into the second wait
    rand_cfg(0);
    cfg_k[0] = 1; cfg_d[0] = 10;
    issue(3'b001); wait_resp(); wait_quiet();

    // reply on the exact timeout cycle, then strays in GAP and in IDLE
    rand_cfg(0);
    cfg_k[1] = 0; cfg_d[1] = T;
    issue(3'b010); wait_resp();
    inject_stray();
    wait_quiet();
    inject_stray();
    repeat (2) @(negedge clk);
    check("stray_two", stray_cnt, 2);

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      rand_cfg(3);
      issue(3'($urandom_range(1, 7)));
      wait_resp(); wait_quiet();
      if ($urandom_range(0, 1) == 1) inject_stray();
    end

    // reset in the middle of WAIT with slots 1 and 2 full
    rand_cfg(0);
    cfg_k[1] = 3; cfg_k[2] = 3;
    issue(3'b110);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    exp_send.delete(); exp_resp.delete(); plan_q.delete();
    stray_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_rdy", req_rdy, 3'b111);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_send_en", send_en, 0);
    check("mid_rst_stray", stray_cnt, 0);
    repeat (2*T + 2*G) @(negedge clk);
    check("post_rst_busy", busy, 0);

    // scheduler still works after the reset
    rand_cfg(1);
    issue(3'b111); wait_resp(); wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
